// File: rtl/host_req_bridge_if.sv
// NASTI (AXI4-style) channel bundle shared by the host message bridge and its sinks.
interface nasti_channel #(
    parameter int unsigned ID_WIDTH   = 1,
    parameter int unsigned ADDR_WIDTH = 64,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned USER_WIDTH = 1
);
    logic [ID_WIDTH-1:0]     aw_id;
    logic [ADDR_WIDTH-1:0]   aw_addr;
    logic [7:0]              aw_len;
    logic [2:0]              aw_size;
    logic [1:0]              aw_burst;
    logic                    aw_lock;
    logic [3:0]              aw_cache;
    logic [2:0]              aw_prot;
    logic [3:0]              aw_qos;
    logic [3:0]              aw_region;
    logic [USER_WIDTH-1:0]   aw_user;
    logic                    aw_valid;
    logic                    aw_ready;

    logic [DATA_WIDTH-1:0]   w_data;
    logic [DATA_WIDTH/8-1:0] w_strb;
    logic                    w_last;
    logic [USER_WIDTH-1:0]   w_user;
    logic                    w_valid;
    logic                    w_ready;

    logic [ID_WIDTH-1:0]     b_id;
    logic [1:0]              b_resp;
    logic [USER_WIDTH-1:0]   b_user;
    logic                    b_valid;
    logic                    b_ready;

    logic [ID_WIDTH-1:0]     ar_id;
    logic [ADDR_WIDTH-1:0]   ar_addr;
    logic [7:0]              ar_len;
    logic [2:0]              ar_size;
    logic [1:0]              ar_burst;
    logic                    ar_lock;
    logic [3:0]              ar_cache;
    logic [2:0]              ar_prot;
    logic [3:0]              ar_qos;
    logic [3:0]              ar_region;
    logic [USER_WIDTH-1:0]   ar_user;
    logic                    ar_valid;
    logic                    ar_ready;

    logic [ID_WIDTH-1:0]     r_id;
    logic [DATA_WIDTH-1:0]   r_data;
    logic [1:0]              r_resp;
    logic                    r_last;
    logic [USER_WIDTH-1:0]   r_user;
    logic                    r_valid;
    logic                    r_ready;

    modport master (
        output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache,
               aw_prot, aw_qos, aw_region, aw_user, aw_valid,
        input  aw_ready,
        output w_data, w_strb, w_last, w_user, w_valid,
        input  w_ready,
        input  b_id, b_resp, b_user, b_valid,
        output b_ready,
        output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache,
               ar_prot, ar_qos, ar_region, ar_user, ar_valid,
        input  ar_ready,
        input  r_id, r_data, r_resp, r_last, r_user, r_valid,
        output r_ready
    );

    modport slave (
        input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache,
               aw_prot, aw_qos, aw_region, aw_user, aw_valid,
        output aw_ready,
        input  w_data, w_strb, w_last, w_user, w_valid,
        output w_ready,
        output b_id, b_resp, b_user, b_valid,
        input  b_ready,
        input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache,
               ar_prot, ar_qos, ar_region, ar_user, ar_valid,
        output ar_ready,
        output r_id, r_data, r_resp, r_last, r_user, r_valid,
        input  r_ready
    );
endinterface

// File: rtl/host_req_bridge.sv
// Buffers 16-bit host id/data messages and issues each as a single-beat NASTI write,
// waiting for the B response before starting the next; tracks sent and error counts.
module host_req_bridge #(
    parameter int unsigned           DATA_WIDTH = 64,
    parameter int unsigned           ADDR_WIDTH = 64,
    parameter int unsigned           ID_WIDTH   = 1,
    parameter int unsigned           USER_WIDTH = 1,
    parameter logic [ADDR_WIDTH-1:0] HOST_ADDR  = '0,
    parameter logic [ID_WIDTH-1:0]   TXN_ID     = '0,
    parameter int unsigned           FIFO_DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [15:0]   req_id,
    input  logic [15:0]   req_data,
    nasti_channel.master  nasti,
    output logic [15:0]   sent_cnt,
    output logic [7:0]    err_cnt,
    output logic          busy
);
    localparam int unsigned     PTR_W    = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0]  FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

    state_t           r_state;
    logic             r_aw_valid;
    logic             r_w_valid;
    logic             r_b_ready;
    logic [31:0]      r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic [15:0]      r_sent_cnt;
    logic [7:0]       r_err_cnt;

    logic             w_full;
    logic             w_push;
    logic             w_pop;
    logic [PTR_W:0]   w_count_next;
    logic             w_unused;

    assign w_full = (r_count == FULL_CNT);
    assign w_push = req_valid && !w_full;
    assign w_pop  = r_w_valid && nasti.w_ready;

    always_comb begin
        w_count_next = r_count;
        if (w_push && !w_pop) begin
            w_count_next = r_count + 1'b1;
        end else if (!w_push && w_pop) begin
            w_count_next = r_count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {req_id, req_data};
        end
    end

    // Valid/ready flags are registered alongside the state so no input reaches them combinationally.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_aw_valid <= 1'b0;
            r_w_valid  <= 1'b0;
            r_b_ready  <= 1'b0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_sent_cnt <= '0;
            r_err_cnt  <= '0;
        end else begin
            r_count <= w_count_next;
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case (r_state)
                IDLE: begin
                    if (r_count != '0) begin
                        r_state    <= ADDR;
                        r_aw_valid <= 1'b1;
                    end
                end
                ADDR: begin
                    if (nasti.aw_ready) begin
                        r_state    <= DATA;
                        r_aw_valid <= 1'b0;
                        r_w_valid  <= 1'b1;
                    end
                end
                DATA: begin
                    if (nasti.w_ready) begin
                        r_state   <= RESP;
                        r_w_valid <= 1'b0;
                        r_b_ready <= 1'b1;
                    end
                end
                RESP: begin
                    if (nasti.b_valid) begin
                        r_sent_cnt <= r_sent_cnt + 1'b1;
                        if (nasti.b_resp != 2'b00 && r_err_cnt != 8'hFF) begin
                            r_err_cnt <= r_err_cnt + 1'b1;
                        end
                        r_b_ready <= 1'b0;
                        if (w_count_next != '0) begin
                            r_state    <= ADDR;
                            r_aw_valid <= 1'b1;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_aw_valid <= 1'b0;
                    r_w_valid  <= 1'b0;
                    r_b_ready  <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready = !w_full;
    assign sent_cnt  = r_sent_cnt;
    assign err_cnt   = r_err_cnt;
    assign busy      = (r_state != IDLE) || (r_count != '0);

    assign nasti.aw_id     = TXN_ID;
    assign nasti.aw_addr   = HOST_ADDR;
    assign nasti.aw_len    = '0;
    assign nasti.aw_size   = 3'($clog2(DATA_WIDTH / 8));
    assign nasti.aw_burst  = 2'b01;
    assign nasti.aw_lock   = 1'b0;
    assign nasti.aw_cache  = '0;
    assign nasti.aw_prot   = '0;
    assign nasti.aw_qos    = '0;
    assign nasti.aw_region = '0;
    assign nasti.aw_user   = '0;
    assign nasti.aw_valid  = r_aw_valid;

    assign nasti.w_data  = DATA_WIDTH'(r_mem[r_rd_ptr]);
    assign nasti.w_strb  = '1;
    assign nasti.w_last  = 1'b1;
    assign nasti.w_user  = '0;
    assign nasti.w_valid = r_w_valid;

    assign nasti.b_ready = r_b_ready;

    assign nasti.ar_id     = '0;
    assign nasti.ar_addr   = '0;
    assign nasti.ar_len    = '0;
    assign nasti.ar_size   = '0;
    assign nasti.ar_burst  = '0;
    assign nasti.ar_lock   = 1'b0;
    assign nasti.ar_cache  = '0;
    assign nasti.ar_prot   = '0;
    assign nasti.ar_qos    = '0;
    assign nasti.ar_region = '0;
    assign nasti.ar_user   = '0;
    assign nasti.ar_valid  = 1'b0;
    assign nasti.r_ready   = 1'b1;

    assign w_unused = ^{nasti.b_id, nasti.b_user, nasti.ar_ready, nasti.r_id, nasti.r_data,
                        nasti.r_resp, nasti.r_last, nasti.r_user, nasti.r_valid};
endmodule

// File: tb/tb_host_req_bridge.sv
// Directed bench for host_req_bridge: a level-driven sink plus a handshake monitor.
module tb_host_req_bridge;
    localparam int unsigned DW    = 64;
    localparam int unsigned AW    = 64;
    localparam logic [63:0] HADDR = 64'h0000_0000_8000_1000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic [15:0] req_id = '0;
    logic [15:0] req_data = '0;
    logic        req_ready;
    logic [15:0] sent_cnt;
    logic [7:0]  err_cnt;
    logic        busy;

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned cyc = 0;

    int unsigned aw_cyc_q[$];
    logic [31:0] w_q[$];
    logic        wlast_q[$];
    logic [31:0] exp_q[$];

    nasti_channel #(.ID_WIDTH(1), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .USER_WIDTH(1)) nasti_if ();

    host_req_bridge #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(1), .USER_WIDTH(1),
        .HOST_ADDR(HADDR), .TXN_ID(1'b0), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_id(req_id), .req_data(req_data), .nasti(nasti_if),
        .sent_cnt(sent_cnt), .err_cnt(err_cnt), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst) begin
            if (nasti_if.aw_valid && nasti_if.aw_ready) aw_cyc_q.push_back(cyc);
            if (nasti_if.w_valid && nasti_if.w_ready) begin
                w_q.push_back(nasti_if.w_data[31:0]);
                wlast_q.push_back(nasti_if.w_last);
            end
        end
        cyc++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sink(input logic awr, input logic wr, input logic bv, input logic [1:0] resp);
        nasti_if.aw_ready = awr;
        nasti_if.w_ready  = wr;
        nasti_if.b_valid  = bv;
        nasti_if.b_resp   = resp;
    endtask

    task automatic clear_q();
        aw_cyc_q.delete();
        w_q.delete();
        wlast_q.delete();
        exp_q.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        clear_q();
    endtask

    task automatic push(input logic [15:0] id, input logic [15:0] d);
        int unsigned n = 0;
        req_valid = 1'b1;
        req_id    = id;
        req_data  = d;
        while (req_ready !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        if (req_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL push_timeout: req_ready=%b expected 1", req_ready);
        end
        tick();
        req_valid = 1'b0;
        exp_q.push_back({id, d});
    endtask

    task automatic wait_idle(input string tag);
        int unsigned n = 0;
        while (busy !== 1'b0 && n < 2000) begin
            tick();
            n++;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_idle_timeout: busy=%b expected 0", tag, busy);
        end
    endtask

    task automatic test_reset();
        sink(1'b1, 1'b1, 1'b1, 2'b00);
        rst = 1'b1;
        tick();
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_req_ready: got %b expected 1", req_ready); end
        checks++; if (nasti_if.aw_valid !== 1'b0) begin errors++; $display("FAIL rst_aw_valid: got %b expected 0", nasti_if.aw_valid); end
        checks++; if (nasti_if.w_valid !== 1'b0) begin errors++; $display("FAIL rst_w_valid: got %b expected 0", nasti_if.w_valid); end
        checks++; if (nasti_if.b_ready !== 1'b0) begin errors++; $display("FAIL rst_b_ready: got %b expected 0", nasti_if.b_ready); end
        checks++; if (nasti_if.ar_valid !== 1'b0) begin errors++; $display("FAIL rst_ar_valid: got %b expected 0", nasti_if.ar_valid); end
        checks++; if (nasti_if.r_ready !== 1'b1) begin errors++; $display("FAIL rst_r_ready: got %b expected 1", nasti_if.r_ready); end
        checks++; if (sent_cnt !== 16'd0) begin errors++; $display("FAIL rst_sent_cnt: got %0d expected 0", sent_cnt); end
        checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL rst_err_cnt: got %0d expected 0", err_cnt); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
        rst = 1'b0;
        clear_q();
    endtask

    task automatic test_single();
        int unsigned pk;
        sink(1'b1, 1'b1, 1'b1, 2'b00);
        push(16'h0003, 16'hABCD);
        pk = cyc - 1;
        checks++; if (nasti_if.aw_valid !== 1'b0) begin errors++; $display("FAIL single_aw_early: got %b expected 0", nasti_if.aw_valid); end
        tick();
        checks++; if (nasti_if.aw_valid !== 1'b1) begin errors++; $display("FAIL single_aw_valid: got %b expected 1", nasti_if.aw_valid); end
        checks++; if (nasti_if.aw_addr !== HADDR) begin errors++; $display("FAIL single_aw_addr: got %h expected %h", nasti_if.aw_addr, HADDR); end
        checks++; if (nasti_if.aw_len !== 8'd0) begin errors++; $display("FAIL single_aw_len: got %0d expected 0", nasti_if.aw_len); end
        checks++; if (nasti_if.aw_size !== 3'd3) begin errors++; $display("FAIL single_aw_size: got %0d expected 3", nasti_if.aw_size); end
        checks++; if (nasti_if.aw_burst !== 2'b01) begin errors++; $display("FAIL single_aw_burst: got %b expected 01", nasti_if.aw_burst); end
        wait_idle("single");
        checks++; if (aw_cyc_q.size() !== 1 || aw_cyc_q[0] !== pk + 2) begin errors++; $display("FAIL single_aw_cycle: got n=%0d at %0d expected 1 at %0d", aw_cyc_q.size(), aw_cyc_q[0], pk + 2); end
        checks++; if (w_q.size() !== 1 || w_q[0] !== 32'h0003ABCD) begin errors++; $display("FAIL single_w_data: got %h expected 0003abcd", w_q[0]); end
        checks++; if (wlast_q[0] !== 1'b1) begin errors++; $display("FAIL single_w_last: got %b expected 1", wlast_q[0]); end
        checks++; if (nasti_if.w_data[63:32] !== 32'h0) begin errors++; $display("FAIL single_w_upper: got %h expected 0", nasti_if.w_data[63:32]); end
        checks++; if (sent_cnt !== 16'd1) begin errors++; $display("FAIL single_sent: got %0d expected 1", sent_cnt); end
        checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL single_err: got %0d expected 0", err_cnt); end
    endtask

    task automatic test_backpressure();
        int unsigned n = 0;
        do_reset();
        sink(1'b0, 1'b1, 1'b1, 2'b00);
        for (int i = 0; i < 4; i++) push(16'h0100 + 16'(i), 16'h5A00 + 16'(i));
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL bp_full_ready: got %b expected 0", req_ready); end
        req_valid = 1'b1;
        req_id    = 16'h0104;
        req_data  = 16'h5A04;
        for (int i = 0; i < 3; i++) tick();
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL bp_fifth_waits: got %b expected 0", req_ready); end
        checks++; if (w_q.size() !== 0) begin errors++; $display("FAIL bp_no_w: got %0d expected 0", w_q.size()); end
        nasti_if.aw_ready = 1'b1;
        while (req_ready !== 1'b1 && n < 50) begin tick(); n++; end
        tick();
        req_valid = 1'b0;
        exp_q.push_back(32'h01045A04);
        wait_idle("bp");
        checks++; if (w_q.size() !== 5) begin errors++; $display("FAIL bp_count: got %0d expected 5", w_q.size()); end
        for (int i = 0; i < 5; i++) begin
            checks++; if (w_q[i] !== exp_q[i]) begin errors++; $display("FAIL bp_order[%0d]: got %h expected %h", i, w_q[i], exp_q[i]); end
        end
        checks++; if (sent_cnt !== 16'd5) begin errors++; $display("FAIL bp_sent: got %0d expected 5", sent_cnt); end
    endtask

    task automatic test_stall();
        int unsigned n = 0;
        do_reset();
        sink(1'b1, 1'b0, 1'b0, 2'b00);
        push(16'h0011, 16'h2222);
        push(16'h0033, 16'h4444);
        while (nasti_if.w_valid !== 1'b1 && n < 20) begin tick(); n++; end
        for (int i = 0; i < 7; i++) begin
            checks++; if (nasti_if.w_valid !== 1'b1 || nasti_if.w_data[31:0] !== 32'h00112222) begin errors++; $display("FAIL stall_w_hold[%0d]: got v=%b d=%h expected v=1 d=00112222", i, nasti_if.w_valid, nasti_if.w_data[31:0]); end
            tick();
        end
        nasti_if.w_ready = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            checks++; if (nasti_if.b_ready !== 1'b1 || nasti_if.aw_valid !== 1'b0) begin errors++; $display("FAIL stall_resp_wait[%0d]: got b_ready=%b aw_valid=%b expected 1 0", i, nasti_if.b_ready, nasti_if.aw_valid); end
            tick();
        end
        checks++; if (aw_cyc_q.size() !== 1) begin errors++; $display("FAIL stall_aw_count: got %0d expected 1", aw_cyc_q.size()); end
        checks++; if (sent_cnt !== 16'd0) begin errors++; $display("FAIL stall_sent_pre: got %0d expected 0", sent_cnt); end
        nasti_if.b_valid = 1'b1;
        tick();
        checks++; if (sent_cnt !== 16'd1) begin errors++; $display("FAIL stall_sent_b: got %0d expected 1", sent_cnt); end
        wait_idle("stall");
        checks++; if (sent_cnt !== 16'd2) begin errors++; $display("FAIL stall_sent: got %0d expected 2", sent_cnt); end
        checks++; if (w_q.size() !== 2 || w_q[1] !== 32'h00334444) begin errors++; $display("FAIL stall_second: got %h expected 00334444", w_q[1]); end
    endtask

    task automatic test_error();
        do_reset();
        sink(1'b1, 1'b1, 1'b1, 2'b00);
        push(16'h0001, 16'h1111);
        wait_idle("err1");
        nasti_if.b_resp = 2'b10;
        push(16'h0002, 16'h2222);
        wait_idle("err2");
        nasti_if.b_resp = 2'b00;
        push(16'h0003, 16'h3333);
        wait_idle("err3");
        checks++; if (err_cnt !== 8'd1) begin errors++; $display("FAIL err_one: got %0d expected 1", err_cnt); end
        checks++; if (sent_cnt !== 16'd3) begin errors++; $display("FAIL err_sent3: got %0d expected 3", sent_cnt); end
        nasti_if.b_resp = 2'b10;
        for (int i = 0; i < 300; i++) push(16'(i), 16'hE000);
        wait_idle("err300");
        checks++; if (err_cnt !== 8'd255) begin errors++; $display("FAIL err_saturate: got %0d expected 255", err_cnt); end
        checks++; if (sent_cnt !== 16'd303) begin errors++; $display("FAIL err_sent303: got %0d expected 303", sent_cnt); end
        nasti_if.b_resp = 2'b00;
    endtask

    task automatic test_reset_mid();
        int unsigned n = 0;
        clear_q();
        sink(1'b1, 1'b0, 1'b1, 2'b00);
        for (int i = 0; i < 3; i++) push(16'h0200 + 16'(i), 16'hC000 + 16'(i));
        while (nasti_if.w_valid !== 1'b1 && n < 20) begin tick(); n++; end
        rst = 1'b1;
        tick();
        checks++; if (nasti_if.aw_valid !== 1'b0 || nasti_if.w_valid !== 1'b0 || nasti_if.b_ready !== 1'b0) begin errors++; $display("FAIL mid_valids: got aw=%b w=%b b=%b expected 0 0 0", nasti_if.aw_valid, nasti_if.w_valid, nasti_if.b_ready); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL mid_req_ready: got %b expected 1", req_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b expected 0", busy); end
        checks++; if (sent_cnt !== 16'd0 || err_cnt !== 8'd0) begin errors++; $display("FAIL mid_counters: got sent=%0d err=%0d expected 0 0", sent_cnt, err_cnt); end
        rst = 1'b0;
        clear_q();
        nasti_if.w_ready = 1'b1;
        push(16'h0777, 16'h8888);
        wait_idle("mid");
        checks++; if (w_q.size() !== 1 || w_q[0] !== 32'h07778888) begin errors++; $display("FAIL mid_after: got n=%0d d=%h expected 1 07778888", w_q.size(), w_q[0]); end
        checks++; if (sent_cnt !== 16'd1) begin errors++; $display("FAIL mid_sent: got %0d expected 1", sent_cnt); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        sink(1'b1, 1'b1, 1'b1, 2'b00);
        for (int i = 0; i < 8; i++) push(16'h0300 + 16'(i), 16'hB000 + 16'(i));
        wait_idle("b2b");
        checks++; if (aw_cyc_q.size() !== 8) begin errors++; $display("FAIL b2b_aw_count: got %0d expected 8", aw_cyc_q.size()); end
        for (int i = 1; i < 8; i++) begin
            checks++; if (aw_cyc_q[i] - aw_cyc_q[i-1] !== 3) begin errors++; $display("FAIL b2b_spacing[%0d]: got %0d expected 3", i, aw_cyc_q[i] - aw_cyc_q[i-1]); end
        end
        for (int i = 0; i < 8; i++) begin
            checks++; if (w_q[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_order[%0d]: got %h expected %h", i, w_q[i], exp_q[i]); end
        end
        checks++; if (sent_cnt !== 16'd8) begin errors++; $display("FAIL b2b_sent: got %0d expected 8", sent_cnt); end
    endtask

    initial begin
        nasti_if.b_id     = '0;
        nasti_if.b_user   = '0;
        nasti_if.ar_ready = 1'b0;
        nasti_if.r_id     = '0;
        nasti_if.r_data   = '0;
        nasti_if.r_resp   = '0;
        nasti_if.r_last   = 1'b0;
        nasti_if.r_user   = '0;
        nasti_if.r_valid  = 1'b0;
        sink(1'b1, 1'b1, 1'b1, 2'b00);
        test_reset();
        test_single();
        test_backpressure();
        test_stall();
        test_error();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
